bsram_stride_checker: RTL
=========================

Name: bsram_stride_checker

Overview:
- Parametrised write-then-readback self-test engine for on-chip block RAM. It is the successor to the fixed 8-bit/11-bit address-stepping BSRAM test.
- Writes COUNT words at a strided address sequence, reads them back, and compares each word against the regenerated pattern.
- Reports pass/fail, error count and first failing address.
- Contains its own inferred single-port RAM with configurable read latency, matching the BSRAM output-register mode, so it is usable stand-alone on board or in simulation.

Parameters:
- DATA_W, 8, RAM word width in bits.
- ADDR_W, 11, RAM address width; depth = 2^ADDR_W.
- BASE_ADDR, 3, first address of the sequence.
- STEP, 3, address increment between entries; must be 1..2^ADDR_W-1.
- COUNT, 16, number of words written and checked; must be 1..floor(2^ADDR_W/STEP).
- SEED, 8'hA5, pattern seed; truncated/zero-extended to DATA_W.
- READ_LAT, 2, RAM read latency in cycles. 1 = bypass output register, 2 = output register enabled.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; starts a run when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the run completes.
- pass  out  1  valid from done onward: 1 = all COUNT words matched.
- err_cnt  out  ADDR_W+1  number of mismatching words in the last run, saturating.
- fail_addr  out  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, pass=0, err_cnt=0, fail_addr=0; internal counters 0. RAM contents are not cleared.
- Addressing:
  - addr_i = (BASE_ADDR + i*STEP) mod 2^ADDR_W, computed incrementally by adding STEP each entry with ADDR_W-bit wrap.
  - Wrap past the top address is legal and expected.
- Pattern: data_i = (SEED + i) mod 2^DATA_W, where i = 0..COUNT-1.
- FSM:
  - IDLE: on start=1, clear err_cnt, fail_addr, pass and the index counter; load addr=BASE_ADDR; go to WRITE. start is ignored in every other state.
  - WRITE: one write per cycle (we=1, addr_i, data_i). After index COUNT-1, reset the index and address and go to READ. The write phase is exactly COUNT cycles.
  - READ: one read issue per cycle for COUNT cycles.
    - The address and expected data are delayed through a READ_LAT-deep pipeline alongside the RAM.
    - A compare strobe fires READ_LAT cycles after each issue.
    - After the last issue, go to DRAIN.
  - DRAIN: wait READ_LAT cycles for outstanding compares, then go to FINISH.
  - FINISH: assert done for 1 cycle; pass = (err_cnt==0); go to IDLE.
- Compare on each strobe: if RAM q != expected, increment err_cnt (saturate at all-ones); if this is the first mismatch, latch fail_addr with the delayed address.
- busy is high in WRITE, READ, DRAIN and FINISH. It is low in the cycle after FINISH, the same cycle done is seen low again.
- Total latency from start to done is COUNT + COUNT + READ_LAT + 2 cycles (start accept and FINISH included).
- A new start on the cycle after done is accepted.
- pass, err_cnt and fail_addr hold until the next accepted start.
- Reset mid-run: immediate return to IDLE with all outputs at reset values; the partially written RAM is left as is.
- The RAM write takes priority; read and write are never issued in the same cycle by construction.

Optional Feature:
- Macro: BSRAM_CHECK_INJECT_EN.
- Defined: adds input inject (1 bit).
  - If inject is high when start is accepted, the write of index 2 (or index COUNT-1 if COUNT<3) stores data_i with bit 0 inverted.
  - The run must then end with pass=0, err_cnt=1, fail_addr=that address.
- Undefined: no inject port, no extra logic; the pattern is always clean.

Test Plan:
- Defaults, one start pulse after reset release → done exactly 36 cycles later; pass=1, err_cnt=0, fail_addr=0.
- Wrap: BASE_ADDR=2040, STEP=3, COUNT=8, ADDR_W=11 → writes hit 2040, 2043, 2046, 1, 4, 7, 10, 13; pass=1.
- READ_LAT=1 vs 2 with COUNT=4 → done at 11 vs 12 cycles after start; pass=1 in both.
- Back-to-back: start again the cycle after done, plus a start pulse during busy (ignored) → exactly two done pulses, both pass=1.
- Async reset asserted mid-READ → busy, done, pass and err_cnt drop to 0 in the same cycle without a clock edge. A subsequent start completes normally with pass=1.
- With BSRAM_CHECK_INJECT_EN, inject=1 at start, defaults → pass=0, err_cnt=1, fail_addr=9 (3 + 2*3).

Source files
------------

// File: rtl/bsram_stride_checker.sv
// Write-then-readback self-test for an inferred block RAM with strided addressing.
// Optional macro BSRAM_CHECK_INJECT_EN adds an `inject` input that corrupts one written word.
module bsram_stride_checker #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int BASE_ADDR = 3,
    parameter int STEP      = 3,
    parameter int COUNT     = 16,
    parameter int SEED      = 8'hA5,
    parameter int READ_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef BSRAM_CHECK_INJECT_EN
    input  logic              inject,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0]     LAST_IDX   = CW'(COUNT - 1);
    localparam logic [CW-1:0]     DRAIN_LAST = CW'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] A_BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] A_STEP     = ADDR_W'(STEP);
    localparam logic [DATA_W-1:0] D_SEED     = DATA_W'(SEED);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] wdata;
    logic              we, re, last, accept;

    logic [READ_LAT-1:0]             vld_pipe;
    logic [READ_LAT-1:0][ADDR_W-1:0] addr_pipe;
    logic [READ_LAT-1:0][DATA_W-1:0] exp_pipe;
    logic [READ_LAT-1:0][DATA_W-1:0] q_pipe;
    logic [DATA_W-1:0]               mem [0:(1<<ADDR_W)-1];

    logic            mism;
    logic [ADDR_W:0] err_nxt;

    assign last   = (idx == LAST_IDX);
    assign accept = (state == IDLE) && start;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = WRITE;
            end
            WRITE: begin
                we = 1'b1;
                if (last) state_nxt = READ;
            end
            READ: begin
                re = 1'b1;
                if (last) state_nxt = DRAIN;
            end
            DRAIN:   if (idx == DRAIN_LAST) state_nxt = FINISH;
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- sequence generator ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            addr <= '0;
            pat  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx  <= '0;
                    addr <= A_BASE;
                    pat  <= D_SEED;
                end
                WRITE, READ: begin
                    if (last) begin
                        idx  <= '0;
                        addr <= A_BASE;
                        pat  <= D_SEED;
                    end else begin
                        idx  <= idx + CW'(1);
                        addr <= addr + A_STEP;
                        pat  <= pat + DATA_W'(1);
                    end
                end
                DRAIN:   idx <= idx + CW'(1);
                default: ;
            endcase
        end
    end

`ifdef BSRAM_CHECK_INJECT_EN
    localparam int INJ_IDX = (COUNT < 3) ? COUNT - 1 : 2;
    logic inj_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      inj_armed <= 1'b0;
        else if (accept) inj_armed <= inject;
    end

    assign wdata = pat ^ {{(DATA_W-1){1'b0}}, (inj_armed && idx == CW'(INJ_IDX))};
`else
    assign wdata = pat;
`endif

    // ---------------- RAM with READ_LAT-deep output path ----------------
    always_ff @(posedge clk) begin
        if (we)      mem[addr] <= wdata;
        else if (re) q_pipe[0] <= mem[addr];
        for (int k = READ_LAT - 1; k > 0; k--) q_pipe[k] <= q_pipe[k-1];
    end

    // Address/expected data travel beside the RAM so they line up with q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            exp_pipe  <= '0;
        end else begin
            for (int k = READ_LAT - 1; k > 0; k--) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                addr_pipe[k] <= addr_pipe[k-1];
                exp_pipe[k]  <= exp_pipe[k-1];
            end
            vld_pipe[0]  <= re;
            addr_pipe[0] <= addr;
            exp_pipe[0]  <= pat;
        end
    end

    // ---------------- compare and results ----------------
    always_comb begin
        mism    = vld_pipe[READ_LAT-1] && (q_pipe[READ_LAT-1] != exp_pipe[READ_LAT-1]);
        err_nxt = err_cnt;
        if (mism && err_cnt != '1) err_nxt = err_cnt + (ADDR_W+1)'(1);
    end

    // pass uses err_nxt so the final compare, landing on the DRAIN exit edge, is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            err_cnt   <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            err_cnt <= err_nxt;
            if (mism && err_cnt == '0) fail_addr <= addr_pipe[READ_LAT-1];
            if (state == DRAIN && idx == DRAIN_LAST) pass <= (err_nxt == '0);
        end
    end

endmodule
